vga_sram_arbiter: RTL and testbench
===================================

# vga_sram_arbiter

Shares the DE2 board's single-port 256K×16 asynchronous SRAM between the VGA display fetch path and a drawing/CPU client port. Runs on the 50 MHz system clock and time-slots the SRAM into alternating display and client cycles, so the display always gets its one fetch per 25 MHz pixel. Client requests are buffered in a 4-entry request FIFO and serviced in free slots. Sits between the VGA timing/pixel pipeline in `top` and the SRAM pins.

## Interface
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 16, SRAM data width
- `FIFO_DEPTH`, 4, client request FIFO depth; power of two, minimum 2

- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pix_phase` out 1: slot phase. 0 is the display slot and 1 is the client slot. VGA_CLK is derived from it.
- `disp_req` in 1: display fetch request; valid only when `pix_phase`=0.
- `disp_addr` in ADDR_W: display fetch address.
- `disp_rdata` out DATA_W: display read data.
- `disp_rvalid` out 1: one-cycle strobe marking valid `disp_rdata`.
- `disp_err` out 1: sticky flag. Set when `disp_req`=1 while `pix_phase`=1.
- `cl_valid` in 1, `cl_ready` out 1: client request handshake.
- `cl_we` in 1: 1 = write, 0 = read.
- `cl_addr` in ADDR_W, `cl_wdata` in DATA_W: client request address and write data.
- `cl_rdata` out DATA_W, `cl_rvalid` out 1: client read return and its one-cycle strobe.
- `sram_addr` out ADDR_W: SRAM address pins.
- `sram_dq_out` out DATA_W, `sram_dq_oe` out 1, `sram_dq_in` in DATA_W: SRAM data bus. The tristate is resolved in `top`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM control pins, active-low.

## Operation
- **Phase.** `pix_phase` toggles every clk.
- **Slot decision.** Made in each cycle for the next SRAM access cycle:
  - Phase 0 with `disp_req`=1: issue a display read.
  - Phase 0 with `disp_req`=0: the slot is donated to the client if the FIFO is non-empty, otherwise the cycle is idle.
  - Phase 1: issue the FIFO head if the FIFO is non-empty, otherwise idle.
- **Access states:** IDLE, DISP_RD, CL_RD, CL_WR. The state is registered and re-decided every cycle; there is no multi-cycle hold.
- **Client FIFO.**
  - `cl_ready` = !full.
  - Push on `cl_valid && cl_ready`. Pop when the head is issued.
  - Push and pop in the same cycle is legal when full: count is unchanged and `cl_ready` stays 0 that cycle.
  - Requests execute strictly in order, so reads return in order, and a read after a write to the same address returns the new data.
- **SRAM pin encoding** (all pins registered):
  - Read: ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - Write: ce_n=0, oe_n=1, we_n=0, dq_oe=1, dq_out=wdata.
  - Idle: ce_n=1, oe_n=1, we_n=1, dq_oe=0.
  - ub_n and lb_n are 0 whenever ce_n=0, otherwise 1.
- **Read capture.** `sram_dq_in` is registered at the end of the access cycle and steered to the display or client return path by a registered tag.
- **`disp_err`.** Cleared only by reset. The offending request is ignored and takes no slot.

## Timing
- **Reset values:**
  - `pix_phase`=0.
  - All SRAM controls deasserted (1); `sram_dq_oe`=0.
  - `sram_addr`, `sram_dq_out`, `disp_rdata`, `cl_rdata` = 0.
  - `disp_rvalid`, `cl_rvalid`, `disp_err` = 0.
  - FIFO empty; `cl_ready`=1.
- **Read latency.** A request decided in cycle T drives the SRAM pins in T+1, and its rvalid/rdata appear in T+2. Display reads therefore always return exactly 2 clk after `disp_req` is sampled.
- **Client latency.** Minimum latency from acceptance to `cl_rvalid` is 3 clk: FIFO push at T, issue decision at T+1 at the earliest, return at T+3.
- **Write/read turnaround.** No bus turnaround cycle. `dq_oe` and `we_n` are registered together, and the SRAM is WE-controlled.
- **Reset mid-operation.** Outstanding reads and FIFO contents are discarded; no rvalid fires after reset release for pre-reset requests.
- **Bandwidth.** Display gets ≤1 access per 2 clk. Client gets ≥1 access per 2 clk, and 2 per 2 clk during blanking.

## Structure
- **Shared package `vga_pkg`:**
  - Access-state enum (IDLE/DISP_RD/CL_RD/CL_WR).
  - Constants SRAM_ADDR_W=18 and SRAM_DATA_W=16.
  - Return-tag encoding (TAG_NONE/TAG_DISP/TAG_CL).
- **Sub-module `sync_fifo`:**
  - Parameterised width/depth, storing {we, addr, wdata}.
  - Ports: push/pop/full/empty, plus count for the bench.
- The arbiter/slot FSM and the pin register bank live in `vga_sram_arbiter`.

## Test plan
- **Reset.** Apply reset, release at 200 ns. Required: all SRAM controls =1 and `cl_ready`=1 before release; `pix_phase` toggling afterward.
- **Display only.**
  - Stimulus: `disp_req` every phase 0 with addr 0..7; SRAM model preloaded with data = addr ^ 16'hA5A5.
  - Required: `disp_rvalid` 2 clk after each request with matching data; no idle gap in phase 0.
- **Client writes then reads.**
  - Stimulus: 4 writes (0x100..0x103 ← 0x1111..0x4444), then 4 reads, with the display active.
  - Required: `cl_ready` drops when 4 entries are pending; reads return 0x1111..0x4444 in order.
- **Blanking donation.**
  - Stimulus: `disp_req`=0, 8 client reads queued.
  - Required: client served on consecutive clk (8 accesses in 8 clk).
- **Error flag.**
  - Stimulus: `disp_req`=1 in phase 1.
  - Required: `disp_err`=1 next cycle and held, no SRAM access for that request.
- **Mid-transfer reset.**
  - Stimulus: assert `rst_n`=0 with 3 FIFO entries and a read in flight.
  - Required: no `cl_rvalid` after release; FIFO empty and `cl_ready`=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA/SRAM arbiter: access states, return tags, SRAM geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // What the SRAM is doing in the current access cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CL_RD   = 2'd2,
        CL_WR   = 2'd3
    } access_e;

    // Which return path a captured read word belongs to
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CL   = 2'd2
    } tag_e;

    // Return tag implied by the registered access state
    function automatic tag_e access_tag(input access_e st);
        case (st)
            DISP_RD: return TAG_DISP;
            CL_RD:   return TAG_CL;
            default: return TAG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO holding client requests ({we, addr, wdata}).
// Latency: pushed word is visible at dout the cycle after the push.
// Backpressure: full blocks push unless a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Time-slots the single-port SRAM between display fetches (phase 0) and a buffered client port.
// Latency: display read 2 clk from disp_req; client read >= 3 clk from acceptance.
// Backpressure: cl_ready = !full on the request FIFO; the display path is never stalled.
module vga_sram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              pix_phase,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic              disp_err,
    input  logic              cl_valid,
    output logic              cl_ready,
    input  logic              cl_we,
    input  logic [ADDR_W-1:0] cl_addr,
    input  logic [DATA_W-1:0] cl_wdata,
    output logic [DATA_W-1:0] cl_rdata,
    output logic              cl_rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int FW = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_phase;
    access_e           r_state;
    access_e           w_state_nxt;
    tag_e              w_tag;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_cnt;
    logic [FW-1:0]     w_fifo_dout;
    logic              w_head_we;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;

    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_dq_out;
    logic              r_sram_dq_oe;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;
    logic [DATA_W-1:0] r_disp_rdata;
    logic              r_disp_rvalid;
    logic              r_disp_err;
    logic [DATA_W-1:0] r_cl_rdata;
    logic              r_cl_rvalid;

    assign {w_head_we, w_head_addr, w_head_wdata} = w_fifo_dout;
    assign cl_ready = !w_fifo_full;
    assign w_push   = cl_valid && !w_fifo_full;
    assign w_pop    = ((w_state_nxt == CL_RD) || (w_state_nxt == CL_WR)) && (w_fifo_cnt != '0);
    assign w_tag    = access_tag(r_state);

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   ({cl_we, cl_addr, cl_wdata}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_cnt)
    );

    // Slot phase: 0 = display slot, 1 = client slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_phase <= 1'b0;
        else        r_phase <= ~r_phase;
    end

    // Access state register: the state is what the SRAM pins do this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Slot decision for the next access cycle; a phase-1 display request is ignored
    always_comb begin
        w_state_nxt = IDLE;
        if (!r_phase && disp_req) begin
            w_state_nxt = DISP_RD;
        end else if (!w_fifo_empty) begin
            w_state_nxt = w_head_we ? CL_WR : CL_RD;
        end
    end

    // SRAM pin bank, loaded from the decision so pins change with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_ce_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
            r_sram_we_n   <= 1'b1;
        end else begin
            case (w_state_nxt)
                DISP_RD: begin
                    r_sram_addr  <= disp_addr;
                    r_sram_dq_oe <= 1'b0;
                    r_sram_ce_n  <= 1'b0;
                    r_sram_oe_n  <= 1'b0;
                    r_sram_we_n  <= 1'b1;
                end
                CL_RD: begin
                    r_sram_addr  <= w_head_addr;
                    r_sram_dq_oe <= 1'b0;
                    r_sram_ce_n  <= 1'b0;
                    r_sram_oe_n  <= 1'b0;
                    r_sram_we_n  <= 1'b1;
                end
                CL_WR: begin
                    r_sram_addr   <= w_head_addr;
                    r_sram_dq_out <= w_head_wdata;
                    r_sram_dq_oe  <= 1'b1;
                    r_sram_ce_n   <= 1'b0;
                    r_sram_oe_n   <= 1'b1;
                    r_sram_we_n   <= 1'b0;
                end
                default: begin
                    r_sram_dq_oe <= 1'b0;
                    r_sram_ce_n  <= 1'b1;
                    r_sram_oe_n  <= 1'b1;
                    r_sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

    // Capture read data at the end of the access cycle and steer it by tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_rdata  <= '0;
            r_disp_rvalid <= 1'b0;
            r_cl_rdata    <= '0;
            r_cl_rvalid   <= 1'b0;
        end else begin
            r_disp_rvalid <= (w_tag == TAG_DISP);
            r_cl_rvalid   <= (w_tag == TAG_CL);
            if (w_tag == TAG_DISP) r_disp_rdata <= sram_dq_in;
            if (w_tag == TAG_CL)   r_cl_rdata   <= sram_dq_in;
        end
    end

    // Sticky flag for display requests made in the client slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_disp_err <= 1'b0;
        else if (disp_req && r_phase) r_disp_err <= 1'b1;
    end

    assign pix_phase   = r_phase;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_ce_n   = r_sram_ce_n;
    assign sram_oe_n   = r_sram_oe_n;
    assign sram_we_n   = r_sram_we_n;
    assign sram_ub_n   = r_sram_ce_n;
    assign sram_lb_n   = r_sram_ce_n;
    assign disp_rdata  = r_disp_rdata;
    assign disp_rvalid = r_disp_rvalid;
    assign disp_err    = r_disp_err;
    assign cl_rdata    = r_cl_rdata;
    assign cl_rvalid   = r_cl_rvalid;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter with a behavioural async SRAM model.
// Latency: checks display 2-clk and client in-order returns.
// Backpressure: exercises FIFO full via cl_ready.
module tb_vga_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_phase;
    logic        disp_req;
    logic [17:0] disp_addr;
    logic [15:0] disp_rdata;
    logic        disp_rvalid;
    logic        disp_err;
    logic        cl_valid;
    logic        cl_ready;
    logic        cl_we;
    logic [17:0] cl_addr;
    logic [15:0] cl_wdata;
    logic [15:0] cl_rdata;
    logic        cl_rvalid;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    vga_sram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_phase   (pix_phase),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_err    (disp_err),
        .cl_valid    (cl_valid),
        .cl_ready    (cl_ready),
        .cl_we       (cl_we),
        .cl_addr     (cl_addr),
        .cl_wdata    (cl_wdata),
        .cl_rdata    (cl_rdata),
        .cl_rvalid   (cl_rvalid),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    // Async SRAM model: low 10 address bits, preloaded with addr ^ 16'hA5A5
    logic [15:0] mem [0:1023];
    logic        mem_init = 1'b0;
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 1024; a++) mem[a] <= a[15:0] ^ 16'hA5A5;
            mem_init <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr[9:0]] <= sram_dq_out;
        end
    end

    // Return monitors, sampled on the falling edge
    logic [15:0] cl_q[$];
    int          disp_rv_cnt = 0;
    int          cyc = 0;
    logic        acc_mon = 1'b0;
    int          acc_n = 0, acc_first = -1, acc_last = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && cl_rvalid)   cl_q.push_back(cl_rdata);
        if (rst_n && disp_rvalid) disp_rv_cnt++;
        if (rst_n && acc_mon && !sram_ce_n && !sram_oe_n) begin
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
            acc_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Background display driver: request every phase-0 slot while enabled
    logic        disp_on = 1'b0;
    logic [17:0] disp_ctr = '0;
    logic        saw_full = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (disp_on) begin
            disp_req  = !pix_phase;
            disp_addr = disp_ctr;
            if (!pix_phase) disp_ctr = (disp_ctr + 18'd1) & 18'h7;
        end
    endtask

    task automatic cl_send(input logic we, input logic [17:0] a, input logic [15:0] d);
        int guard = 0;
        cl_valid = 1'b1; cl_we = we; cl_addr = a; cl_wdata = d;
        while (!cl_ready && guard < 50) begin
            saw_full = 1'b1;
            step();
            guard++;
        end
        if (guard >= 50) chk("cl_send_timeout", 32'd0, 32'd1);
        step();
        cl_valid = 1'b0;
    endtask

    task automatic wait_cl(input int n);
        int guard = 0;
        while (cl_q.size() < n && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("cl_return_timeout", 32'(cl_q.size()), 32'(n));
    endtask

    initial begin
        logic p0;
        rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cl_valid = 1'b0; cl_we = 1'b0; cl_addr = '0; cl_wdata = '0;

        // Reset state
        #100;
        chk("rst_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_cl_ready", cl_ready, 1);
        chk("rst_phase", pix_phase, 0);
        chk("rst_rvalid", {disp_rvalid, cl_rvalid, disp_err}, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_data", {disp_rdata, cl_rdata}, 0);
        #100;
        rst_n = 1'b1;
        step();
        p0 = pix_phase;
        chk("phase_after_rel", p0, 1);
        step();
        chk("phase_toggle", pix_phase, {31'd0, ~p0});

        // Display only: addr 0..7 in consecutive phase-0 slots
        if (pix_phase) step();
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) chk($sformatf("disp_rd%0d", i - 1), {15'd0, disp_rvalid, disp_rdata},
                           {15'd0, 1'b1, 16'(i - 1) ^ 16'hA5A5});
            disp_req = (i < 8); disp_addr = 18'(i);
            step();
            disp_req = 1'b0;
            if (i < 8) chk($sformatf("disp_pins%0d", i), {12'd0, sram_ce_n, sram_oe_n, sram_addr},
                           {14'd0, 18'(i)});
            step();
        end

        // Client writes then reads with the display running
        disp_on = 1'b1;
        cl_q.delete();
        for (int i = 0; i < 4; i++) cl_send(1'b1, 18'h100 + 18'(i), 16'h1111 * 16'(i + 1));
        for (int i = 0; i < 4; i++) cl_send(1'b0, 18'h100 + 18'(i), 16'h0);
        wait_cl(4);
        chk("cl_saw_full", saw_full, 1);
        chk("cl_rd_count", cl_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cl_q.size()) chk($sformatf("cl_rd%0d", i), cl_q[i], 16'h1111 * 16'(i + 1));
        disp_on = 1'b0; disp_req = 1'b0;
        repeat (6) step();

        // Blanking donation: 8 reads served on consecutive clocks
        cl_q.delete();
        acc_mon = 1'b1;
        for (int i = 0; i < 8; i++) cl_send(1'b0, 18'(i), 16'h0);
        wait_cl(8);
        repeat (3) step();
        acc_mon = 1'b0;
        chk("blank_acc_n", acc_n, 8);
        chk("blank_span", acc_last - acc_first, 7);
        chk("blank_rd_count", cl_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < cl_q.size()) chk($sformatf("blank_rd%0d", i), cl_q[i], 16'(i) ^ 16'hA5A5);

        // Error flag: display request in the client slot
        if (!pix_phase) step();
        disp_rv_cnt = 0;
        chk("err_before", disp_err, 0);
        disp_req = 1'b1; disp_addr = 18'h5;
        step();
        disp_req = 1'b0;
        chk("err_set", disp_err, 1);
        chk("err_no_access1", sram_ce_n, 1);
        step();
        chk("err_no_access2", sram_ce_n, 1);
        repeat (4) step();
        chk("err_held", disp_err, 1);
        chk("err_no_rvalid", disp_rv_cnt, 0);

        // Mid-transfer reset with the FIFO partly full and reads in flight
        disp_on = 1'b1;
        for (int i = 0; i < 5; i++) cl_send(1'b0, 18'(i), 16'h0);
        rst_n = 1'b0;
        disp_on = 1'b0; disp_req = 1'b0;
        cl_q.delete();
        #1;
        chk("mrst_ready", cl_ready, 1);
        chk("mrst_ce", sram_ce_n, 1);
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("mrst_no_rvalid", cl_q.size(), 0);
        chk("mrst_ready_after", cl_ready, 1);
        chk("mrst_fifo_cnt", dut.w_fifo_cnt, 0);
        chk("mrst_ce_after", sram_ce_n, 1);
        chk("mrst_err_clr", disp_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
